// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor.
// One full-adder slice plus a carry flop walks a WIDTH-bit operand pair
// LSB-first, one bit per clock. Operands are captured on start, the sum is
// collected in a shift register, and s/c0/ovf are loaded only at completion
// so partial sums never appear on the outputs.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c0,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             sub_q;
  logic             carry;

  logic             b_bit;
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;

  // Full-adder slice on the current LSBs; B is inverted in subtract mode.
  always_comb begin
    b_bit      = b_sh[0] ^ sub_q;
    sum_bit    = a_sh[0] ^ b_bit ^ carry;
    carry_next = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);
    last_bit   = (count == LAST_BIT);
  end

  // Sequencing: IDLE waits for start, RUN walks the bits, DONE lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            count <= '0;
          end
        end
        RUN: begin
          if (last_bit) begin
            state <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand capture and per-bit shifting; the carry flop is preloaded so
  // that subtraction becomes a + ~b + ~c through the same slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sh  <= a;
        b_sh  <= b;
        sub_q <= sub;
        carry <= sub ? ~c : c;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= {sum_bit, sum_sh[WIDTH-1:1]};
        carry  <= carry_next;
      end
    end
  end

  // Result registers load only on the last bit; carry still holds the
  // carry into the MSB at that point, which gives the overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s   <= '0;
      c0  <= 1'b0;
      ovf <= 1'b0;
    end else if (state == RUN && last_bit) begin
      s   <= {sum_bit, sum_sh[WIDTH-1:1]};
      c0  <= carry_next;
      ovf <= carry ^ carry_next;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=3.
// Expected results come from an arithmetic model and are queued when an
// operation is launched; a negedge monitor pops and compares on each done.
module tb_serial_adder;

  typedef struct packed {
    logic       ovf;
    logic       c0;
    logic [7:0] s;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  logic       start8, sub8, c8;
  logic [7:0] a8, b8;
  logic       busy8, done8, c0_8, ovf8;
  logic [7:0] s8;

  logic       start3, sub3, c3;
  logic [2:0] a3, b3;
  logic       busy3, done3, c0_3, ovf3;
  logic [2:0] s3;

  res_t q8[$];
  res_t q3[$];

  int check_count = 0;
  int pass_count  = 0;

  res_t prev8;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .c(c8),
    .busy(busy8), .done(done8), .s(s8), .c0(c0_8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .sub(sub3), .a(a3), .b(b3), .c(c3),
    .busy(busy3), .done(done3), .s(s3), .c0(c0_3), .ovf(ovf3)
  );

  // Arithmetic reference: full-width sum, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [7:0] ta, input logic [7:0] tb,
                                 input logic tc, input logic tsub);
    logic [8:0] mask;
    logic [8:0] bb;
    logic [8:0] sum;
    res_t r;
    mask  = 9'((1 << w) - 1);
    bb    = tsub ? (~{1'b0, tb} & mask) : {1'b0, tb};
    sum   = {1'b0, ta} + bb + {8'd0, tc ^ tsub};
    r.s   = sum[7:0] & mask[7:0];
    r.c0  = sum[w];
    r.ovf = (ta[w-1] == bb[w-1]) && (r.s[w-1] != ta[w-1]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Launch one WIDTH=8 operation; returns #1 after the edge that sampled start.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                               input logic tsub, input bit expect_result);
    a8 = ta; b8 = tb; c8 = tc; sub8 = tsub; start8 = 1'b1;
    if (expect_result) q8.push_back(model(8, ta, tb, tc, tsub));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Bounded wait for done8, then step past the DONE cycle.
  task automatic waitDone8();
    int n;
    n = 0;
    while (!done8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done8) checkOutput("done8 timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (done8) begin
      res_t e;
      checkOutput("busy8 during done", {31'd0, busy8}, 32'd0);
      if (q8.size() == 0) begin
        checkOutput("spurious done8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("s8", {24'd0, s8}, {24'd0, e.s});
        checkOutput("c0_8", {31'd0, c0_8}, {31'd0, e.c0});
        checkOutput("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (done3) begin
      res_t e;
      if (q3.size() == 0) begin
        checkOutput("spurious done3", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        checkOutput("s3", {29'd0, s3}, {24'd0, e.s});
        checkOutput("c0_3", {31'd0, c0_3}, {31'd0, e.c0});
        checkOutput("ovf3", {31'd0, ovf3}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; sub8 = 1'b0;
    start3 = 1'b1; a3 = 3'd5; b3 = 3'd3; c3 = 1'b0; sub3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy8", {31'd0, busy8}, 32'd0);
    checkOutput("reset done8", {31'd0, done8}, 32'd0);
    checkOutput("reset s8", {24'd0, s8}, 32'd0);
    checkOutput("reset c0_8", {31'd0, c0_8}, 32'd0);
    checkOutput("reset ovf8", {31'd0, ovf8}, 32'd0);
    checkOutput("reset busy3", {31'd0, busy3}, 32'd0);
    rst = 1'b0; start8 = 1'b0; start3 = 1'b0;
    @(posedge clk); #1;
    checkOutput("no busy after start with rst", {31'd0, busy8}, 32'd0);

    // Add wrap with cycle-exact busy/done timing.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("busy8 in run", {31'd0, busy8}, 32'd1);
      checkOutput("done8 early", {31'd0, done8}, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("busy8 at done", {31'd0, busy8}, 32'd0);
    checkOutput("done8 pulse", {31'd0, done8}, 32'd1);
    @(posedge clk); #1;
    checkOutput("done8 one cycle", {31'd0, done8}, 32'd0);

    // Signed overflow and subtract cases.
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1); waitDone8();
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 1'b1); waitDone8();
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, 1'b1); waitDone8();
    prev8 = model(8, 8'h05, 8'h07, 1'b1, 1'b1);

    // Inputs toggle during RUN/DONE; result must use captured operands only.
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) checkOutput("s8 stable in run", {24'd0, s8}, {24'd0, prev8.s});
      a8 = 8'($urandom); b8 = 8'($urandom);
      sub8 = 1'($urandom); c8 = 1'($urandom); start8 = 1'($urandom);
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle after protocol", {31'd0, busy8}, 32'd0);

    // Reset in the 4th RUN cycle abandons the operation.
    applyStimulus(8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst busy8", {31'd0, busy8}, 32'd0);
    checkOutput("midrst done8", {31'd0, done8}, 32'd0);
    checkOutput("midrst s8", {24'd0, s8}, 32'd0);
    checkOutput("midrst c0_8", {31'd0, c0_8}, 32'd0);
    checkOutput("midrst ovf8", {31'd0, ovf8}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midrst stays idle", {31'd0, busy8}, 32'd0);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1); waitDone8();

    // WIDTH=3 exhaustive, start held high: one op every WIDTH+2 cycles.
    start3 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] cv;
      cv = 8'(i);
      a3 = cv[7:5]; b3 = cv[4:2]; c3 = cv[1]; sub3 = cv[0];
      q3.push_back(model(3, {5'd0, cv[7:5]}, {5'd0, cv[4:2]}, cv[1], cv[0]));
      repeat (5) @(posedge clk);
      #1;
    end
    start3 = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    checkOutput("q8 drained", q8.size(), 32'd0);
    checkOutput("q3 drained", q3.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
